// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer: walks FETCH/DECODE/EXEC/MEM for the 3-bit opcode
// set, owns the shared memory port via req/ready, and counts retired instructions.
module instr_sequencer #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ir_op,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic [1:0]       alu_op,
    output logic             rf_we,
    output logic             rf_wsel,
    output logic             busy,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    localparam logic [2:0] OP_STORE = 3'd4;
    localparam logic [2:0] OP_LOAD  = 3'd5;
    localparam logic [2:0] OP_JUMP  = 3'd6;
    localparam logic [2:0] OP_HALT  = 3'd7;

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, HALT, ERR
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              waiting;
    logic              retire;
    logic              limit_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            retired  <= '0;
        end else begin
            state    <= next_state;
            // Any non-waiting cycle clears the counter, so every FETCH/MEM entry starts at 0.
            wait_cnt <= waiting ? wait_cnt + WAIT_W'(1) : '0;
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        alu_op     = 2'b00;
        rf_we      = 1'b0;
        rf_wsel    = 1'b0;
        busy       = 1'b0;
        halted     = 1'b0;
        mem_err    = 1'b0;
        waiting    = 1'b0;
        retire     = 1'b0;
        // The limit is judged on the registered count, so ready in that same cycle still completes.
        limit_hit  = (TIMEOUT != 0) && (wait_cnt == WAIT_MAX);

        case (state)
            IDLE: begin
                if (start) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                mem_req = 1'b1;
                busy    = 1'b1;
                if (mem_ready) begin
                    ir_load    = 1'b1;
                    pc_inc     = 1'b1;
                    next_state = DECODE;
                end else if (limit_hit) begin
                    next_state = ERR;
                end else begin
                    waiting = 1'b1;
                end
            end
            DECODE: begin
                busy = 1'b1;
                case (ir_op)
                    OP_STORE, OP_LOAD: next_state = MEM;
                    OP_HALT:           next_state = HALT;
                    default:           next_state = EXEC;
                endcase
            end
            EXEC: begin
                busy       = 1'b1;
                alu_op     = ir_op[1:0];
                next_state = FETCH;
                retire     = 1'b1;
                if (ir_op == OP_JUMP) begin
                    pc_load = 1'b1;
                end else if (!ir_op[2]) begin
                    rf_we = 1'b1;
                end
            end
            MEM: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (ir_op == OP_STORE);
                if (mem_ready) begin
                    next_state = FETCH;
                    retire     = 1'b1;
                    if (ir_op == OP_LOAD) begin
                        rf_we   = 1'b1;
                        rf_wsel = 1'b1;
                    end
                end else if (limit_hit) begin
                    next_state = ERR;
                end else begin
                    waiting = 1'b1;
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            ERR: begin
                mem_err = 1'b1;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule
